// File: rtl/ram_io_responder.sv
// ram_io_responder: byte-wide CPU bus responder with RAM, UART RX/TX, cycle counter, stop register.
// Optional BUS_RANGE_CHECK_EN: out-of-range accesses read 0xFF, drop writes, set bus_err.
module ram_io_responder #(
    parameter int RAM_ADDR_W  = 17,
    parameter int TX_DEPTH    = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_pop,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        program_stop,
`ifdef BUS_RANGE_CHECK_EN
    output logic        bus_err,
`endif
    output logic        tx_overflow
);

    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]            ram [2**RAM_ADDR_W];
    logic [7:0]            fifo [TX_DEPTH];
    logic [PW-1:0]         wptr, rptr;
    logic [CW-1:0]         count, count_next;
    logic [31:0]           counter, latch;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic [7:0]            rdata, push_data;
    logic                  io, rd, wr, oor, ram_we;
    logic                  io_rx, io_cnt, io_stop;
    logic                  push_req, push, pop, full, full_next;
    logic                  unused;

    assign io       = mem_a[17:16] == 2'b11;
    assign ram_addr = mem_a[RAM_ADDR_W-1:0];
    assign rd       = rdy_in && !mem_wr;
    assign wr       = rdy_in && mem_wr;
    assign io_rx    = io && mem_a[15:0] == 16'h0000;
    assign io_cnt   = io && mem_a[15:2] == 14'h0001;
    assign io_stop  = io && mem_a[15:0] == 16'h0004;

`ifdef BUS_RANGE_CHECK_EN
    assign oor = !io && (mem_a[31:18] != 14'd0 ||
                 mem_a[17:0] >= 18'(2**RAM_ADDR_W));
`else
    assign oor = 1'b0;
`endif

    assign ram_we    = wr && !io && !oor;
    assign push_req  = wr && ((io_rx && mem_dout != 8'h00) || io_stop);
    assign push_data = io_stop ? 8'h00 : mem_dout;
    assign pop       = tx_valid && tx_ready;
    assign full      = count == CW'(TX_DEPTH);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    assign push      = push_req && (!full || pop);
    assign tx_valid  = count != '0;
    assign tx_data   = tx_valid ? fifo[rptr] : 8'h00;
    assign unused    = ^{latch[7:0], mem_a[31:18]};

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CW'(1);
        else if (pop && !push)
            count_next = count - CW'(1);
    end

    assign full_next = (CW'(TX_DEPTH) - count_next) <= CW'(FULL_MARGIN);

    always_comb begin
        rdata = 8'h00;
        unique case (1'b1)
            oor:         rdata = 8'hFF;
            !io:         rdata = ram[ram_addr];
            io_rx:       rdata = rx_valid ? rx_data : 8'h00;
            io_cnt: begin
                unique case (mem_a[1:0])
                    2'd0:    rdata = counter[7:0];
                    2'd1:    rdata = latch[15:8];
                    2'd2:    rdata = latch[23:16];
                    default: rdata = latch[31:24];
                endcase
            end
            default:     rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (ram_we)
            ram[ram_addr] <= mem_dout;
        if (push)
            fifo[wptr] <= push_data;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mem_din        <= 8'h00;
            rx_pop         <= 1'b0;
            wptr           <= '0;
            rptr           <= '0;
            count          <= '0;
            io_buffer_full <= 1'b0;
            counter        <= 32'd0;
            latch          <= 32'd0;
            program_stop   <= 1'b0;
            tx_overflow    <= 1'b0;
`ifdef BUS_RANGE_CHECK_EN
            bus_err        <= 1'b0;
`endif
        end else begin
            rx_pop <= rd && io_rx && rx_valid;
            if (rd)
                mem_din <= rdata;
            if (rd && io_cnt && mem_a[1:0] == 2'd0)
                latch <= counter;
            if (rdy_in && !program_stop)
                counter <= counter + 32'd1;
            if (wr && io_stop)
                program_stop <= 1'b1;
            if (push_req && !push)
                tx_overflow <= 1'b1;
            if (push)
                wptr <= wptr + PW'(1);
            if (pop)
                rptr <= rptr + PW'(1);
            count          <= count_next;
            io_buffer_full <= full_next;
`ifdef BUS_RANGE_CHECK_EN
            if (rdy_in && oor)
                bus_err <= 1'b1;
`endif
        end
    end

endmodule

// File: doc/ram_io_responder.md
Name: ram_io_responder

Overview:
- Memory-side responder for the CPU's byte-wide bus (address, write data, write strobe, read data).
- Contains a 128 KB byte-addressed RAM and the I/O window at mem_a[17:16]==2'b11.
- I/O window: UART RX byte pop, UART TX byte push through a TX FIFO, cycle counter, and program-stop register.
- Sits between the CPU top and the UART/board logic. Drives the CPU's mem_din and io_buffer_full.

Parameters:
- RAM_ADDR_W, 17, RAM address bits (2^17 bytes).
- TX_DEPTH, 8, TX FIFO entries (power of 2, >=4).
- FULL_MARGIN, 2, io_buffer_full asserts when free TX entries <= FULL_MARGIN.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  bus qualifier; all side effects are gated when low
- mem_a  input  32  byte address from CPU (only [17:0] decoded)
- mem_dout  input  8  write data from CPU
- mem_wr  input  1  1 = write, 0 = read
- mem_din  output  8  read data to CPU, valid the cycle after the read address
- io_buffer_full  output  1  TX FIFO near-full indication to CPU
- rx_valid  input  1  UART RX byte available
- rx_data  input  8  UART RX byte
- rx_pop  output  1  1-cycle pulse: RX byte consumed
- tx_valid  output  1  TX FIFO non-empty
- tx_data  output  8  TX FIFO head byte
- tx_ready  input  1  UART accepts head byte (pop when tx_valid && tx_ready)
- program_stop  output  1  sticky; set by a write to 0x30004
- tx_overflow  output  1  sticky; a TX push was dropped because the FIFO was full

Behaviour:
- Reset (rst_in=0, async): mem_din=0, rx_pop=0, TX FIFO empty (tx_valid=0, tx_data=0), io_buffer_full=0, program_stop=0, tx_overflow=0, counter=0, counter latch=0. RAM contents are not reset.
- Decode: io = (mem_a[17:16]==2'b11); otherwise RAM at mem_a[RAM_ADDR_W-1:0].
- Transactions: every cycle with rdy_in=1 is one transaction. When rdy_in=0 there are no RAM writes and no FIFO push or pop by the bus, and mem_din holds. The UART-side TX pop still runs.
- RAM read: mem_din <= ram[addr] at the next clk_in edge (latency 1).
- RAM write: ram[addr] <= mem_dout at the same edge. The write takes 1 cycle; the CPU does not wait.
- IO read 0x30000: if rx_valid, then mem_din <= rx_data and rx_pop pulses for 1 cycle. Otherwise mem_din <= 0x00 and there is no pop.
- IO read 0x30004..0x30007 (byte k = mem_a[1:0]):
  - Byte 0 snapshots the counter into the latch and returns counter[7:0].
  - Bytes 1..3 return latch[8k+7:8k], so a 4-byte read is coherent.
- IO write 0x30000: non-zero data is pushed to the TX FIFO; 0x00 is ignored.
- IO write 0x30004: sets program_stop and pushes 0x00 to the TX FIFO.
- Other IO addresses: reads return 0x00; writes are ignored.
- TX FIFO: circular buffer with read/write pointers and a count.
  - Simultaneous push and pop in the same cycle leaves the count unchanged, including when the FIFO is full (the push is accepted).
  - A push when full with no pop is dropped and sets tx_overflow.
  - Pointers wrap modulo TX_DEPTH.
  - io_buffer_full is registered: 1 when (TX_DEPTH - count_next) <= FULL_MARGIN.
- Counter: 32-bit, increments each cycle while rdy_in=1 and program_stop=0. Wraps 0xFFFFFFFF -> 0. Freezes once program_stop is set.
- Reset mid-operation: all state clears immediately, and a pending read response is lost.

Optional Feature:
- Macro: BUS_RANGE_CHECK_EN.
- With it defined:
  - Non-IO addresses with mem_a[17:0] >= 0x20000, or mem_a[31:18] != 0, are out of range.
  - Out-of-range reads return 0xFF; out-of-range writes are ignored.
  - A sticky output bus_err (1 bit, reset 0) is set on any out-of-range access.
- Without it: the bus_err port is absent and addresses alias modulo 2^RAM_ADDR_W.

Test Plan:
- RAM access: write 0xA5 to 0x00010, then read 0x00010 on the next cycle -> mem_din = 0xA5 one cycle after the read address. Reading 0x00011 (unwritten, preloaded 0x3C) -> 0x3C.
- RX: rx_valid=1, rx_data=0x41, read 0x30000 -> mem_din=0x41, rx_pop high exactly 1 cycle. Repeat with rx_valid=0 -> mem_din=0x00, no pop.
- TX fill (TX_DEPTH=8, tx_ready=0):
  - Write 0x00 to 0x30000 -> no push, tx_valid stays 0.
  - Write 0x31..0x38 -> io_buffer_full=1 after the 6th push.
  - 9th write -> dropped, tx_overflow=1.
  - Set tx_ready=1 -> 8 bytes drain in order 0x31..0x38.
- Counter: after reset, 100 cycles with rdy_in=1 and 20 cycles with rdy_in=0, then read 0x30004..0x30007 -> bytes assemble to 100, plus the cycles elapsed until the byte-0 read. Byte 3 equals the latched value even though the counter has advanced.
- Stop: write any value to 0x30004 -> program_stop=1, one 0x00 appears on tx_data, counter value frozen on later reads. Assert rst_in low mid-drain -> all outputs return to reset values asynchronously.
